// File: rtl/pattern_array_rot.sv
// Rotating bit-pattern register exposed as a ROWS x COLS array, with load, position counter and wrap pulse.
// Optional PATTERN_ARRAY_INV_EN adds an inv input that inverts the pattern after any rotation.
module pattern_array_rot #(
    parameter int                     ROWS      = 2,
    parameter int                     COLS      = 3,
    parameter logic [ROWS*COLS-1:0]   RESET_PAT = 6'b010011
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ld,
    input  logic [ROWS*COLS-1:0]             ld_data,
    input  logic                             en,
    input  logic                             dir,
`ifdef PATTERN_ARRAY_INV_EN
    input  logic                             inv,
`endif
    output logic                             dq [ROWS-1:0][COLS:1],
    output logic                             any_o,
    output logic [$clog2(ROWS*COLS+1)-1:0]   cnt,
    output logic                             wrap,
    output logic                             busy
);

    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    flat_q, flat_d;
    logic [N-1:0]    rot_l, rot_r, rot;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wrap_q, wrap_d;
    logic            any_q, any_d;

    // Index arithmetic instead of slices so N=1 degenerates to an identity rotate.
    always_comb begin
        rot_l = '0;
        rot_r = '0;
        for (int i = 0; i < N; i++) begin
            rot_l[i] = flat_q[(i + N - 1) % N];
            rot_r[i] = flat_q[(i + 1) % N];
        end
    end

    always_comb begin
        state_d = state_q;
        flat_d  = flat_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        rot     = flat_q;
        if (ld) begin
            flat_d  = ld_data;
            cnt_d   = '0;
            state_d = IDLE;
        end else begin
            if (en) begin
                state_d = RUN;
                if (!dir) begin
                    rot = rot_l;
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    rot = rot_r;
                    if (cnt_q == '0) begin
                        cnt_d  = CW'(N - 1);
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end else begin
                state_d = IDLE;
            end
            flat_d = rot;
`ifdef PATTERN_ARRAY_INV_EN
            if (inv) begin
                flat_d = ~rot;
            end
`endif
        end
        any_d = |flat_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            flat_q  <= RESET_PAT;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            any_q   <= |RESET_PAT;
        end else begin
            state_q <= state_d;
            flat_q  <= flat_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            any_q   <= any_d;
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 1; c <= COLS; c++) begin
                dq[r][c] = flat_q[r * COLS + c - 1];
            end
        end
    end

    assign any_o = any_q;
    assign cnt   = cnt_q;
    assign wrap  = wrap_q;
    assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_pattern_array_rot.sv
// Directed bench for pattern_array_rot at default parameters (2x3, reset pattern 010011).
module tb_pattern_array_rot;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld;
    logic [5:0] ld_data;
    logic       en;
    logic       dir;
    logic       dq [1:0][3:1];
    logic       any_o;
    logic [2:0] cnt;
    logic       wrap;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    pattern_array_rot dut (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .ld_data (ld_data),
        .en      (en),
        .dir     (dir),
        .dq      (dq),
        .any_o   (any_o),
        .cnt     (cnt),
        .wrap    (wrap),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] get_flat();
        logic [5:0] f;
        for (int r = 0; r < 2; r++)
            for (int c = 1; c <= 3; c++)
                f[r * 3 + c - 1] = dq[r][c];
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ld = 1'b0; en = 1'b0; dir = 1'b0; ld_data = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (get_flat() !== 6'b010011) begin
            tests_failed++; $display("FAIL reset_flat: got %b want 010011", get_flat());
        end
        tests_run++;
        if ({cnt, any_o, busy, wrap} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_status: got cnt=%0d any=%b busy=%b wrap=%b want 0 1 0 0", cnt, any_o, busy, wrap);
        end
    endtask

    task automatic test_rotate_left();
        logic [5:0] exp_flat [6] = '{6'b100110, 6'b001101, 6'b011010, 6'b110100, 6'b101001, 6'b010011};
        logic [2:0] exp_cnt  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        do_reset();
        en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            tests_run++;
            if (get_flat() !== exp_flat[i] || cnt !== exp_cnt[i] || wrap !== (i == 5) ||
                busy !== 1'b1 || any_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL rot_left step %0d: got flat=%b cnt=%0d wrap=%b busy=%b any=%b want %b %0d %b 1 1",
                         i, get_flat(), cnt, wrap, busy, any_o, exp_flat[i], exp_cnt[i], (i == 5));
            end
        end
        en = 1'b0;
        step();
        tests_run++;
        if (get_flat() !== 6'b010011 || cnt !== 3'd0 || wrap !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold: got flat=%b cnt=%0d wrap=%b busy=%b want 010011 0 0 0", get_flat(), cnt, wrap, busy);
        end
    endtask

    task automatic test_load();
        do_reset();
        en = 1'b1; dir = 1'b0;
        step();
        ld = 1'b1; ld_data = 6'b000000;
        step();
        tests_run++;
        if (get_flat() !== 6'b000000 || any_o !== 1'b0 || cnt !== 3'd0 || busy !== 1'b0 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_zero: got flat=%b any=%b cnt=%0d busy=%b wrap=%b want 000000 0 0 0 0",
                     get_flat(), any_o, cnt, busy, wrap);
        end
        ld = 1'b0;
        step();
        tests_run++;
        if (get_flat() !== 6'b000000 || busy !== 1'b1 || cnt !== 3'd1 || any_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_then_run: got flat=%b busy=%b cnt=%0d any=%b want 000000 1 1 0",
                     get_flat(), busy, cnt, any_o);
        end
        ld = 1'b1; ld_data = 6'b000001; en = 1'b0;
        step();
        ld = 1'b0; en = 1'b1; dir = 1'b1;
        step();
        tests_run++;
        if (get_flat() !== 6'b100000 || cnt !== 3'd5 || wrap !== 1'b1 || dq[1][3] !== 1'b1 || dq[0][1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_rot_right: got flat=%b cnt=%0d wrap=%b want 100000 5 1", get_flat(), cnt, wrap);
        end
        step();
        tests_run++;
        if (get_flat() !== 6'b010000 || cnt !== 3'd4 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL rot_right_2: got flat=%b cnt=%0d wrap=%b want 010000 4 0", get_flat(), cnt, wrap);
        end
        en = 1'b0;
    endtask

    task automatic test_dir_change();
        do_reset();
        en = 1'b1; dir = 1'b1;
        step();
        tests_run++;
        if (get_flat() !== 6'b101001 || cnt !== 3'd5 || wrap !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rot_right_wrap: got flat=%b cnt=%0d wrap=%b busy=%b want 101001 5 1 1",
                     get_flat(), cnt, wrap, busy);
        end
        dir = 1'b0;
        step();
        tests_run++;
        if (get_flat() !== 6'b010011 || cnt !== 3'd0 || wrap !== 1'b1) begin
            tests_failed++;
            $display("FAIL dir_switch: got flat=%b cnt=%0d wrap=%b want 010011 0 1", get_flat(), cnt, wrap);
        end
        step();
        tests_run++;
        if (get_flat() !== 6'b100110 || cnt !== 3'd1 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL dir_left_after: got flat=%b cnt=%0d wrap=%b want 100110 1 0", get_flat(), cnt, wrap);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        en = 1'b1; dir = 1'b0;
        repeat (3) step();
        tests_run++;
        if (get_flat() !== 6'b011010 || cnt !== 3'd3) begin
            tests_failed++;
            $display("FAIL mid_run_pre: got flat=%b cnt=%0d want 011010 3", get_flat(), cnt);
        end
        rst = 1'b1; ld = 1'b1; ld_data = 6'b111100;
        step();
        tests_run++;
        if (get_flat() !== 6'b010011 || cnt !== 3'd0 || busy !== 1'b0 || wrap !== 1'b0 || any_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_run_reset: got flat=%b cnt=%0d busy=%b wrap=%b any=%b want 010011 0 0 0 1",
                     get_flat(), cnt, busy, wrap, any_o);
        end
        rst = 1'b0; ld = 1'b0; en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ld = 1'b0; ld_data = '0; en = 1'b0; dir = 1'b0;
        #2;
        test_reset();
        test_rotate_left();
        test_load();
        test_dir_change();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pattern_array_rot.md
PATTERN_ARRAY_ROT -- requirements
Module: pattern_array_rot

Interface
REQ-001 Parameter ROWS, default 2: first unpacked dimension of dq, legal 1..16.
REQ-002 Parameter COLS, default 3: second unpacked dimension of dq, legal 1..16; N = ROWS*COLS.
REQ-003 Parameter RESET_PAT, default 6'b010011 (width N): pattern loaded on reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ld  input  1  load request; ld_data captured next edge.
REQ-007 ld_data  input  N  flat pattern to load.
REQ-008 en  input  1  rotate enable.
REQ-009 dir  input  1  rotate direction: 0 = left (toward higher index), 1 = right.
REQ-010 dq  output  bit [ROWS-1:0][COLS:1] (unpacked)  registered pattern array.
REQ-011 any_o  output  1  registered OR-reduction of all dq bits.
REQ-012 cnt  output  $clog2(N+1)  rotation position, 0..N-1.
REQ-013 wrap  output  1  one-cycle pulse on cnt wrap.
REQ-014 busy  output  1  high while in RUN state.

Function
REQ-015 Flat mapping: element dq[r][c] SHALL equal flat bit r*COLS + (c-1).
REQ-016 States: IDLE, RUN; IDLE->RUN when en=1 and ld=0; RUN->IDLE when en=0 or ld=1.
REQ-017 Priority per edge: rst > ld > en rotate > hold.
REQ-018 ld=1: flat pattern <= ld_data, cnt <= 0, wrap <= 0, state <= IDLE, regardless of en.
REQ-019 Rotate (en=1, ld=0), dir=0: flat bit i <= bit i-1, bit 0 <= bit N-1; dir=1: bit i <= bit i+1, bit N-1 <= bit 0.
REQ-020 Rotate updates dq in the same edge en is sampled (latency 1 cycle); busy reflects state after that edge.
REQ-021 cnt increments mod N on left rotate, decrements mod N on right rotate (0 -> N-1).
REQ-022 wrap SHALL be 1 for exactly the cycle after cnt transitions N-1->0 (left) or 0->N-1 (right); else 0.
REQ-023 en=0, ld=0: dq, cnt held; wrap 0.
REQ-024 N=1: rotate leaves dq unchanged, cnt stays 0, wrap pulses every rotate cycle.
REQ-025 any_o SHALL equal OR of the dq value it is registered with (same cycle as dq).
REQ-026 dir changes between cycles take effect on the next rotate with no bubble.

Reset
REQ-027 rst=1 at edge: flat pattern <= RESET_PAT, cnt <= 0, wrap <= 0, busy <= 0, state IDLE, any_o <= |RESET_PAT.
REQ-028 Reset mid-rotation SHALL discard pending ld/en that same edge.

Configuration
REQ-029 Macro PATTERN_ARRAY_INV_EN: when defined, input inv (1 bit) is present; on each edge with inv=1 and ld=0, every flat bit is inverted after any rotation that edge; cnt unaffected.
REQ-030 Without PATTERN_ARRAY_INV_EN: no inv port; behaviour per REQ-015..026 only.

Verification
REQ-031 Defaults, rst 1 cycle -> dq flat = 010011, cnt=0, any_o=1, busy=0, wrap=0.
REQ-032 After reset, en=1 dir=0 for 6 cycles -> flat 100110, 001101, 011010, 110100, 101001, 010011; cnt 1..5,0; wrap=1 only after 6th edge.
REQ-033 ld=1 ld_data=000000 with en=1 -> dq all 0, any_o=0, cnt=0, busy=0; next en cycle busy=1, dq still 0.
REQ-034 Reset value, en=1 dir=1 one cycle -> flat 101001, cnt=5, wrap=1.
REQ-035 Mid-run (cnt=3) assert rst with ld=1 -> dq = RESET_PAT, cnt=0, busy=0.
REQ-036 With PATTERN_ARRAY_INV_EN, reset value, en=1 dir=0 inv=1 -> flat 011001, cnt=1, any_o=1.
